// File: rtl/spiketpu_pkg.sv
// Shared spike TPU definitions: weight-path defaults and the column feeder state encoding.
package spiketpu_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 1;
  localparam int unsigned DEFAULT_ROWS       = 8;
  localparam int unsigned DEFAULT_TILE_W     = 8;

  typedef enum logic [2:0] {
    FEED_IDLE,
    FEED_FETCH,
    FEED_WAIT_PE,
    FEED_LOAD,
    FEED_DONE
  } feeder_state_e;

endpackage

// File: rtl/weight_col_feeder_if.sv
// Feeder bus: controller handshake, weight FIFO read side and PE column load side.
interface weight_col_feeder_if
  import spiketpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned TILE_W     = DEFAULT_TILE_W
);
  logic                  start;
  logic                  abort;
  logic [TILE_W-1:0]     n_tiles;
  logic                  busy;
  logic                  done;
  logic                  fifo_r_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  pe_ready;
  logic                  w_shift;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_load;

  // master is the feeder; slave is the controller/FIFO/column side
  modport master (
    input  start, abort, n_tiles, fifo_empty, fifo_data, pe_ready,
    output busy, done, fifo_r_en, w_shift, w_data, w_load
  );

  modport slave (
    output start, abort, n_tiles, fifo_empty, fifo_data, pe_ready,
    input  busy, done, fifo_r_en, w_shift, w_data, w_load
  );
endinterface

// File: rtl/weight_col_feeder.sv
// Pops ROWS weights per tile from the weight FIFO, shifts them down a PE column,
// then strobes w_load; repeats for n_tiles under a start/busy/done handshake.
module weight_col_feeder
  import spiketpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ROWS       = DEFAULT_ROWS,
  parameter int unsigned TILE_W     = DEFAULT_TILE_W
) (
  input  logic                clk,
  input  logic                rstn,
  weight_col_feeder_if.master bus
);

  localparam int unsigned CW = $clog2(ROWS + 1);

  feeder_state_e state_q, state_d;

  logic [TILE_W-1:0]     tiles_q;
  logic [TILE_W-1:0]     tile_cnt;
  logic [CW-1:0]         issue_cnt;
  logic [CW-1:0]         shift_cnt;
  logic                  rd_pend;

  logic                  busy_q;
  logic                  done_q;
  logic                  w_shift_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic                  w_load_q;

  logic rd_acc_c;
  logic start_ok_c;
  logic start_zero_c;
  logic shift_c;
  logic last_shift_c;
  logic last_tile_c;
  logic tile_done_c;

  // A pending read whose data lands in an abort cycle is dropped
  assign shift_c      = rd_pend && !bus.abort;
  // Leave FETCH as the final weight is registered so w_load trails it by one cycle
  assign last_shift_c = rd_pend && (shift_cnt == CW'(ROWS - 1));
  assign last_tile_c  = ((tile_cnt + TILE_W'(1)) == tiles_q);
  assign tile_done_c  = (state_q == FEED_LOAD) && !bus.abort;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= FEED_IDLE;
    else       state_q <= state_d;
  end

  // Next state and read issue
  always_comb begin
    state_d      = state_q;
    rd_acc_c     = 1'b0;
    start_ok_c   = 1'b0;
    start_zero_c = 1'b0;
    case (state_q)
      FEED_IDLE: begin
        if (bus.start) begin
          if (bus.n_tiles != '0) begin
            start_ok_c = 1'b1;
            state_d    = FEED_FETCH;
          end else begin
            start_zero_c = 1'b1;
          end
        end
      end
      FEED_FETCH: begin
        rd_acc_c = !bus.fifo_empty && (issue_cnt < CW'(ROWS));
        if (last_shift_c) state_d = FEED_WAIT_PE;
      end
      FEED_WAIT_PE: begin
        if (bus.pe_ready) state_d = FEED_LOAD;
      end
      FEED_LOAD: begin
        state_d = last_tile_c ? FEED_DONE : FEED_FETCH;
      end
      FEED_DONE: begin
        state_d = FEED_IDLE;
      end
      default: begin
        state_d = FEED_IDLE;
      end
    endcase
    if (bus.abort && (state_q != FEED_IDLE)) begin
      state_d  = FEED_IDLE;
      rd_acc_c = 1'b0;
    end
  end

  // Counters and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tiles_q   <= '0;
      tile_cnt  <= '0;
      issue_cnt <= '0;
      shift_cnt <= '0;
      rd_pend   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_shift_q <= 1'b0;
      w_data_q  <= '0;
      w_load_q  <= 1'b0;
    end else begin
      busy_q    <= (state_d != FEED_IDLE);
      done_q    <= (state_d == FEED_DONE) || start_zero_c;
      w_load_q  <= (state_d == FEED_LOAD);
      w_shift_q <= shift_c;
      rd_pend   <= rd_acc_c;
      if (shift_c) w_data_q <= bus.fifo_data;

      if (start_ok_c) begin
        tiles_q   <= bus.n_tiles;
        tile_cnt  <= '0;
        issue_cnt <= '0;
        shift_cnt <= '0;
      end else if (tile_done_c) begin
        tile_cnt  <= tile_cnt + TILE_W'(1);
        issue_cnt <= '0;
        shift_cnt <= '0;
      end else begin
        if (rd_acc_c) issue_cnt <= issue_cnt + CW'(1);
        if (shift_c)  shift_cnt <= shift_cnt + CW'(1);
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fifo_r_en = rd_acc_c;
  assign bus.w_shift   = w_shift_q;
  assign bus.w_data    = w_data_q;
  assign bus.w_load    = w_load_q;

endmodule

// File: tb/tb_weight_col_feeder.sv
// Bench for weight_col_feeder: FIFO model, event monitor and per-scenario checks (ROWS=4).
module tb_weight_col_feeder;

  localparam int unsigned ROWS = 4;
  localparam int unsigned DW   = 1;
  localparam int unsigned TW   = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  weight_col_feeder_if #(.DATA_WIDTH(DW), .TILE_W(TW)) bus ();

  weight_col_feeder #(.DATA_WIDTH(DW), .ROWS(ROWS), .TILE_W(TW)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int compared = 0;
  int mismatched = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: registered output, one pop per accepted read
  logic [DW-1:0] fmem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [DW-1:0] exp_q[$];

  assign bus.fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (bus.fifo_r_en && (rd_ptr != wr_ptr)) begin
      bus.fifo_data <= fmem[rd_ptr[9:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Event log sampled mid-cycle
  logic [DW-1:0] sh_data[$];
  int sh_cyc[$];
  int rd_cyc[$];
  int ld_cyc[$];
  int done_cnt = 0;
  int busy_cnt = 0;
  int both_cnt = 0;
  int empty_rd = 0;
  always @(negedge clk) begin
    if (bus.fifo_r_en) begin
      rd_cyc.push_back(cyc);
      if (bus.fifo_empty) empty_rd++;
    end
    if (bus.w_shift) begin
      sh_data.push_back(bus.w_data);
      sh_cyc.push_back(cyc);
    end
    if (bus.w_load) ld_cyc.push_back(cyc);
    if (bus.w_shift && bus.w_load) both_cnt++;
    if (bus.done) done_cnt++;
    if (bus.busy) busy_cnt++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fmem[wr_ptr[9:0]] = w;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(w);
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
    exp_q.delete();
  endtask

  task automatic kick(input int n);
    bus.n_tiles = TW'(n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (!bus.busy) break;
      tick();
    end
    ok = !bus.busy;
  endtask

  task automatic wait_shifts(input int target, input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (sh_data.size() >= target) break;
      tick();
    end
    ok = (sh_data.size() >= target);
  endtask

  task automatic test_reset();
    tick(2);
    compared++; if (bus.busy !== 1'b0)      begin $display("FAIL reset_busy: got %b want 0", bus.busy); mismatched++; end
    compared++; if (bus.done !== 1'b0)      begin $display("FAIL reset_done: got %b want 0", bus.done); mismatched++; end
    compared++; if (bus.fifo_r_en !== 1'b0) begin $display("FAIL reset_r_en: got %b want 0", bus.fifo_r_en); mismatched++; end
    compared++; if (bus.w_shift !== 1'b0)   begin $display("FAIL reset_w_shift: got %b want 0", bus.w_shift); mismatched++; end
    compared++; if (bus.w_data !== '0)      begin $display("FAIL reset_w_data: got %b want 0", bus.w_data); mismatched++; end
    compared++; if (bus.w_load !== 1'b0)    begin $display("FAIL reset_w_load: got %b want 0", bus.w_load); mismatched++; end
    rstn = 1'b1;
    tick(2);
  endtask

  task automatic test_basic_tile();
    int bs, br, bl, bd, bb;
    bit ok;
    bs = sh_data.size(); br = rd_cyc.size(); bl = ld_cyc.size(); bd = done_cnt; bb = busy_cnt;
    push(1'b1); push(1'b0); push(1'b1); push(1'b1);
    bus.pe_ready = 1'b1;
    kick(1);
    wait_idle(60, ok);
    compared++; if (!ok) begin $display("FAIL basic_timeout: got busy want idle"); mismatched++; end
    compared++; if (sh_data.size() - bs != 4) begin $display("FAIL basic_shifts: got %0d want 4", sh_data.size() - bs); mismatched++; end
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      compared++; if (sh_data[bs+i] !== e) begin $display("FAIL basic_data[%0d]: got %b want %b", i, sh_data[bs+i], e); mismatched++; end
      compared++; if (sh_cyc[bs+i] != rd_cyc[br+i] + 2) begin $display("FAIL basic_latency[%0d]: got %0d want %0d", i, sh_cyc[bs+i], rd_cyc[br+i] + 2); mismatched++; end
    end
    compared++; if (ld_cyc.size() - bl != 1) begin $display("FAIL basic_loads: got %0d want 1", ld_cyc.size() - bl); mismatched++; end
    compared++; if (ld_cyc[bl] != sh_cyc[bs+3] + 1) begin $display("FAIL basic_load_cycle: got %0d want %0d", ld_cyc[bl], sh_cyc[bs+3] + 1); mismatched++; end
    compared++; if (done_cnt - bd != 1) begin $display("FAIL basic_done: got %0d want 1", done_cnt - bd); mismatched++; end
    compared++; if (busy_cnt - bb != 8) begin $display("FAIL basic_busy_cycles: got %0d want 8", busy_cnt - bb); mismatched++; end
    compared++; if (rd_cyc.size() - br != 4) begin $display("FAIL basic_reads: got %0d want 4", rd_cyc.size() - br); mismatched++; end
  endtask

  task automatic test_empty_stall();
    int bs, br, bl, bd, be, pc;
    bit ok;
    bs = sh_data.size(); br = rd_cyc.size(); bl = ld_cyc.size(); bd = done_cnt; be = empty_rd;
    push(DW'($urandom)); push(DW'($urandom));
    bus.pe_ready = 1'b1;
    kick(1);
    tick(4);
    pc = cyc;
    push(DW'($urandom)); push(DW'($urandom));
    wait_idle(60, ok);
    compared++; if (!ok) begin $display("FAIL stall_timeout: got busy want idle"); mismatched++; end
    compared++; if (sh_data.size() - bs != 4) begin $display("FAIL stall_shifts: got %0d want 4", sh_data.size() - bs); mismatched++; end
    compared++; if (rd_cyc.size() - br != 4) begin $display("FAIL stall_reads: got %0d want 4", rd_cyc.size() - br); mismatched++; end
    compared++; if (empty_rd != be) begin $display("FAIL stall_read_when_empty: got %0d want 0", empty_rd - be); mismatched++; end
    compared++; if (rd_cyc[br+2] != pc) begin $display("FAIL stall_resume_read: got %0d want %0d", rd_cyc[br+2], pc); mismatched++; end
    compared++; if (sh_cyc[bs+2] - sh_cyc[bs+1] != pc + 2 - (rd_cyc[br+1] + 2)) begin $display("FAIL stall_gap: got %0d want %0d", sh_cyc[bs+2] - sh_cyc[bs+1], pc - rd_cyc[br+1]); mismatched++; end
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      compared++; if (sh_data[bs+i] !== e) begin $display("FAIL stall_data[%0d]: got %b want %b", i, sh_data[bs+i], e); mismatched++; end
    end
    compared++; if (ld_cyc.size() - bl != 1) begin $display("FAIL stall_loads: got %0d want 1", ld_cyc.size() - bl); mismatched++; end
    compared++; if (done_cnt - bd != 1) begin $display("FAIL stall_done: got %0d want 1", done_cnt - bd); mismatched++; end
  endtask

  task automatic test_backpressure();
    int bs, br, bl, bd, bx;
    bit ok;
    bs = sh_data.size(); br = rd_cyc.size(); bl = ld_cyc.size(); bd = done_cnt; bx = both_cnt;
    for (int i = 0; i < 12; i++) push(DW'($urandom));
    bus.pe_ready = 1'b0;
    kick(3);
    for (int t = 0; t < 3; t++) begin
      wait_shifts(bs + 4 * (t + 1), 60, ok);
      compared++; if (!ok) begin $display("FAIL bp_shift_timeout[%0d]: got %0d want %0d", t, sh_data.size() - bs, 4 * (t + 1)); mismatched++; end
      tick(10);
      bus.pe_ready = 1'b1;
      for (int i = 0; i < 20 && ld_cyc.size() < bl + t + 1; i++) tick();
      bus.pe_ready = 1'b0;
      compared++; if (ld_cyc.size() < bl + t + 1) begin $display("FAIL bp_load_timeout[%0d]: got %0d want %0d", t, ld_cyc.size() - bl, t + 1); mismatched++; end
    end
    wait_idle(60, ok);
    compared++; if (!ok) begin $display("FAIL bp_timeout: got busy want idle"); mismatched++; end
    compared++; if (ld_cyc.size() - bl != 3) begin $display("FAIL bp_loads: got %0d want 3", ld_cyc.size() - bl); mismatched++; end
    compared++; if (sh_data.size() - bs != 12) begin $display("FAIL bp_shifts: got %0d want 12", sh_data.size() - bs); mismatched++; end
    compared++; if (rd_cyc.size() - br != 12) begin $display("FAIL bp_reads: got %0d want 12", rd_cyc.size() - br); mismatched++; end
    compared++; if (done_cnt - bd != 1) begin $display("FAIL bp_done: got %0d want 1", done_cnt - bd); mismatched++; end
    compared++; if (both_cnt != bx) begin $display("FAIL bp_shift_with_load: got %0d want 0", both_cnt - bx); mismatched++; end
    for (int i = 0; i < 12; i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      compared++; if (sh_data[bs+i] !== e) begin $display("FAIL bp_data[%0d]: got %b want %b", i, sh_data[bs+i], e); mismatched++; end
    end
    for (int t = 0; t < 3; t++) begin
      int s, l, v;
      s = sh_cyc[bs + 4*t + 3];
      l = ld_cyc[bl + t];
      v = 0;
      for (int k = br; k < rd_cyc.size(); k++) if (rd_cyc[k] > s && rd_cyc[k] < l) v++;
      compared++; if (v != 0) begin $display("FAIL bp_read_in_wait[%0d]: got %0d want 0", t, v); mismatched++; end
      compared++; if (l - s != 12) begin $display("FAIL bp_wait_len[%0d]: got %0d want 12", t, l - s); mismatched++; end
    end
  endtask

  task automatic test_edge_inputs();
    int bs, br, bl, bd;
    bit ok;
    // n_tiles == 0 with data waiting: done only, no reads
    push(DW'($urandom)); push(DW'($urandom)); push(DW'($urandom)); push(DW'($urandom));
    bus.pe_ready = 1'b1;
    br = rd_cyc.size(); bd = done_cnt;
    kick(0);
    compared++; if (bus.done !== 1'b1) begin $display("FAIL zero_done: got %b want 1", bus.done); mismatched++; end
    compared++; if (bus.busy !== 1'b0) begin $display("FAIL zero_busy: got %b want 0", bus.busy); mismatched++; end
    tick();
    compared++; if (bus.done !== 1'b0) begin $display("FAIL zero_done_width: got %b want 0", bus.done); mismatched++; end
    tick(3);
    compared++; if (rd_cyc.size() - br != 0) begin $display("FAIL zero_reads: got %0d want 0", rd_cyc.size() - br); mismatched++; end
    compared++; if (done_cnt - bd != 1) begin $display("FAIL zero_done_count: got %0d want 1", done_cnt - bd); mismatched++; end

    // start while busy is ignored
    bs = sh_data.size(); bl = ld_cyc.size(); bd = done_cnt;
    kick(1);
    tick(2);
    bus.n_tiles = TW'(5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_idle(60, ok);
    compared++; if (!ok) begin $display("FAIL busy_start_timeout: got busy want idle"); mismatched++; end
    compared++; if (ld_cyc.size() - bl != 1) begin $display("FAIL busy_start_loads: got %0d want 1", ld_cyc.size() - bl); mismatched++; end
    compared++; if (sh_data.size() - bs != 4) begin $display("FAIL busy_start_shifts: got %0d want 4", sh_data.size() - bs); mismatched++; end
    compared++; if (done_cnt - bd != 1) begin $display("FAIL busy_start_done: got %0d want 1", done_cnt - bd); mismatched++; end
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      compared++; if (sh_data[bs+i] !== e) begin $display("FAIL busy_start_data[%0d]: got %b want %b", i, sh_data[bs+i], e); mismatched++; end
    end

    // abort together with start in IDLE: start wins
    for (int i = 0; i < 4; i++) push(DW'($urandom));
    bs = sh_data.size(); bl = ld_cyc.size(); bd = done_cnt;
    bus.n_tiles = TW'(1);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    compared++; if (bus.busy !== 1'b1) begin $display("FAIL start_abort_busy: got %b want 1", bus.busy); mismatched++; end
    wait_idle(60, ok);
    compared++; if (ld_cyc.size() - bl != 1) begin $display("FAIL start_abort_loads: got %0d want 1", ld_cyc.size() - bl); mismatched++; end
    compared++; if (done_cnt - bd != 1) begin $display("FAIL start_abort_done: got %0d want 1", done_cnt - bd); mismatched++; end
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      compared++; if (sh_data[bs+i] !== e) begin $display("FAIL start_abort_data[%0d]: got %b want %b", i, sh_data[bs+i], e); mismatched++; end
    end
  endtask

  task automatic test_abort();
    int bs, br, bl, bd, x, late_sh, late_rd, nsh;
    bit ok;
    flush();
    for (int i = 0; i < 8; i++) push(DW'($urandom));
    bs = sh_data.size(); br = rd_cyc.size(); bl = ld_cyc.size(); bd = done_cnt;
    bus.pe_ready = 1'b1;
    kick(2);
    wait_shifts(bs + 2, 40, ok);
    compared++; if (!ok) begin $display("FAIL abort_shift_timeout: got %0d want 2", sh_data.size() - bs); mismatched++; end
    x = cyc;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    compared++; if (bus.busy !== 1'b0) begin $display("FAIL abort_busy: got %b want 0", bus.busy); mismatched++; end
    tick(10);
    late_sh = 0; late_rd = 0;
    for (int k = bs; k < sh_cyc.size(); k++) if (sh_cyc[k] > x) late_sh++;
    for (int k = br; k < rd_cyc.size(); k++) if (rd_cyc[k] >= x) late_rd++;
    nsh = sh_data.size() - bs;
    compared++; if (ld_cyc.size() - bl != 0) begin $display("FAIL abort_loads: got %0d want 0", ld_cyc.size() - bl); mismatched++; end
    compared++; if (done_cnt - bd != 0) begin $display("FAIL abort_done: got %0d want 0", done_cnt - bd); mismatched++; end
    compared++; if (late_sh != 0) begin $display("FAIL abort_late_shift: got %0d want 0", late_sh); mismatched++; end
    compared++; if (late_rd != 0) begin $display("FAIL abort_late_read: got %0d want 0", late_rd); mismatched++; end
    compared++; if ((rd_cyc.size() - br) - nsh > 1) begin $display("FAIL abort_lost_pops: got %0d want <=1", (rd_cyc.size() - br) - nsh); mismatched++; end
    for (int i = 0; i < nsh; i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      compared++; if (sh_data[bs+i] !== e) begin $display("FAIL abort_data[%0d]: got %b want %b", i, sh_data[bs+i], e); mismatched++; end
    end
    flush();
  endtask

  task automatic test_async_reset();
    int bs, bl, bd;
    bit ok;
    flush();
    for (int i = 0; i < 4; i++) push(DW'($urandom));
    bus.pe_ready = 1'b1;
    bd = done_cnt;
    kick(1);
    compared++; if (bus.fifo_r_en !== 1'b1) begin $display("FAIL areset_pre_r_en: got %b want 1", bus.fifo_r_en); mismatched++; end
    #2 rstn = 1'b0;
    #1;
    compared++; if (bus.busy !== 1'b0)      begin $display("FAIL areset_busy: got %b want 0", bus.busy); mismatched++; end
    compared++; if (bus.fifo_r_en !== 1'b0) begin $display("FAIL areset_r_en: got %b want 0", bus.fifo_r_en); mismatched++; end
    compared++; if (bus.w_shift !== 1'b0)   begin $display("FAIL areset_w_shift: got %b want 0", bus.w_shift); mismatched++; end
    compared++; if (bus.w_data !== '0)      begin $display("FAIL areset_w_data: got %b want 0", bus.w_data); mismatched++; end
    compared++; if (bus.w_load !== 1'b0)    begin $display("FAIL areset_w_load: got %b want 0", bus.w_load); mismatched++; end
    tick(2);
    rstn = 1'b1;
    tick(3);
    compared++; if (done_cnt != bd) begin $display("FAIL areset_done: got %0d want 0", done_cnt - bd); mismatched++; end
    flush();
    for (int i = 0; i < 4; i++) push(DW'($urandom));
    bs = sh_data.size(); bl = ld_cyc.size(); bd = done_cnt;
    kick(1);
    wait_idle(60, ok);
    compared++; if (!ok) begin $display("FAIL areset_timeout: got busy want idle"); mismatched++; end
    compared++; if (sh_data.size() - bs != 4) begin $display("FAIL areset_shifts: got %0d want 4", sh_data.size() - bs); mismatched++; end
    compared++; if (ld_cyc.size() - bl != 1) begin $display("FAIL areset_loads: got %0d want 1", ld_cyc.size() - bl); mismatched++; end
    compared++; if (done_cnt - bd != 1) begin $display("FAIL areset_done_after: got %0d want 1", done_cnt - bd); mismatched++; end
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      compared++; if (sh_data[bs+i] !== e) begin $display("FAIL areset_data[%0d]: got %b want %b", i, sh_data[bs+i], e); mismatched++; end
    end
  endtask

  task automatic test_random_tiles();
    for (int it = 0; it < 6; it++) begin
      int n, bs, bl, bd, bb;
      bit ok;
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n * int'(ROWS); i++) push(DW'($urandom));
      bs = sh_data.size(); bl = ld_cyc.size(); bd = done_cnt; bb = busy_cnt;
      bus.pe_ready = 1'b1;
      kick(n);
      wait_idle(200, ok);
      compared++; if (!ok) begin $display("FAIL rand%0d_timeout: got busy want idle", it); mismatched++; end
      compared++; if (ld_cyc.size() - bl != n) begin $display("FAIL rand%0d_loads: got %0d want %0d", it, ld_cyc.size() - bl, n); mismatched++; end
      compared++; if (done_cnt - bd != 1) begin $display("FAIL rand%0d_done: got %0d want 1", it, done_cnt - bd); mismatched++; end
      compared++; if (busy_cnt - bb != n * (int'(ROWS) + 3) + 1) begin $display("FAIL rand%0d_busy_cycles: got %0d want %0d", it, busy_cnt - bb, n * (int'(ROWS) + 3) + 1); mismatched++; end
      compared++; if (sh_data.size() - bs != n * int'(ROWS)) begin $display("FAIL rand%0d_shifts: got %0d want %0d", it, sh_data.size() - bs, n * int'(ROWS)); mismatched++; end
      for (int i = 0; i < n * int'(ROWS); i++) begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        compared++; if (sh_data[bs+i] !== e) begin $display("FAIL rand%0d_data[%0d]: got %b want %b", it, i, sh_data[bs+i], e); mismatched++; end
      end
      tick(2);
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.n_tiles  = '0;
    bus.pe_ready = 1'b0;
    test_reset();
    test_basic_tile();
    test_empty_stall();
    test_backpressure();
    test_edge_inputs();
    test_abort();
    test_async_reset();
    test_random_tiles();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want summary");
    $fatal(1);
  end

endmodule
